// File: rtl/accum_pkg.sv
// Shared defaults and state encoding for the sample accumulator.
package accum_pkg;

    localparam int unsigned AccWidth = 32;
    localparam int unsigned AccLenW  = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StDone  = 2'd2
    } state_e;

endpackage

// File: rtl/adder_32.sv
// Ripple-agnostic binary adder with carry in/out; width defaults to 32 bits.
module adder_32
    import accum_pkg::*;
#(
    parameter int unsigned Width = AccWidth
) (
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    input  logic             cin_i,
    output logic [Width-1:0] s_o,
    output logic             cout_o
);

    // One extra bit on each operand captures the carry-out.
    assign {cout_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{Width{1'b0}}, cin_i};

endmodule

// File: rtl/accum_32.sv
// Accumulates a programmed number of streamed samples and hands the
// wrapped sum plus a sticky carry flag downstream via valid/ready.
module accum_32
    import accum_pkg::*;
#(
    parameter int unsigned WIDTH = AccWidth,
    parameter int unsigned LEN_W = AccLenW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf,
    output logic             busy
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;

    adder_32 #(
        .Width (WIDTH)
    ) u_adder (
        .a_i    (acc_q),
        .b_i    (in_data),
        .cin_i  (1'b0),
        .s_o    (add_sum),
        .cout_o (add_cout)
    );

    // Next-state, datapath update and handshake outputs.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        rem_d     = rem_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    rem_d   = len;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = (len == '0) ? StDone : StAccum;
                end
            end
            StAccum: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d = add_sum;
                    ovf_d = ovf_q | add_cout;
                    rem_d = rem_q - 1'b1;
                    // Counting down from len means 2^LEN_W-1 never overflows.
                    if (rem_q == LEN_W'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Accumulator, sticky carry and remaining-sample count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
            rem_q <= '0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            rem_q <= rem_d;
        end
    end

    // Result is only exposed while it is being offered.
    assign out_sum = out_valid ? acc_q : '0;
    assign out_ovf = out_valid & ovf_q;
    assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_accum_32.sv
// Randomized scoreboard bench for accum_32: the stimulus pushes the
// expected sum/overflow, a negedge monitor pops on each accepted result.
module tb_accum_32;

    localparam int unsigned W  = 32;
    localparam int unsigned LW = 8;

    logic          clk       = 1'b0;
    logic          reset     = 1'b0;
    logic          start     = 1'b0;
    logic [LW-1:0] len       = '0;
    logic          in_valid  = 1'b0;
    logic [W-1:0]  in_data   = '0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_sum;
    logic          out_ovf;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] exp_sum_q[$];
    logic         exp_ovf_q[$];
    int unsigned  smp[$];

    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_sum   = '0;
    logic         prev_ovf   = 1'b0;

    always #5 clk = ~clk;

    accum_32 #(
        .WIDTH (W),
        .LEN_W (LW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: consumes results on handshake and checks stall stability.
    always @(negedge clk) begin
        if (reset) begin
            chk("busy_state", busy, in_ready | out_valid);
            chk("ready_valid_excl", in_ready & out_valid, 0);
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_sum", out_sum, prev_sum);
                chk("hold_ovf", out_ovf, prev_ovf);
            end
            if (out_valid && out_ready) begin
                chk("scoreboard_has_entry", exp_sum_q.size() > 0, 1);
                if (exp_sum_q.size() > 0) begin
                    chk("out_sum", out_sum, exp_sum_q.pop_front());
                    chk("out_ovf", out_ovf, exp_ovf_q.pop_front());
                end
            end
            prev_stall <= out_valid && !out_ready;
            prev_sum   <= out_sum;
            prev_ovf   <= out_ovf;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    // Reference model: true sum of samples; any carry occurred iff it reached 2^W.
    task automatic push_expected(input int n);
        longint unsigned tot = 0;
        for (int i = 0; i < n; i++) tot += 64'(smp[i]);
        exp_sum_q.push_back(tot[W-1:0]);
        exp_ovf_q.push_back(tot >= 64'h1_0000_0000);
    endtask

    // Runs one accumulation; entered and left at a negedge.
    task automatic run_acc(input int n, input int gmin, input int gmax, input int rdly,
                           input bit poke);
        push_expected(n);
        start = 1'b1;
        len   = LW'(n);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            int g;
            g = $urandom_range(gmax, gmin);
            repeat (g) begin
                @(negedge clk);
                chk("in_ready_gap", in_ready, 1);
                chk("no_early_valid", out_valid, 0);
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = smp[i];
            @(negedge clk);
            chk("in_ready_accept", in_ready, 1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_data  = $urandom;
        end
        @(negedge clk);
        chk("result_latency", out_valid, 1);
        repeat (rdly) begin
            start = poke;
            len   = LW'($urandom);
            @(posedge clk); #1;
            start = 1'b0;
        end
        out_ready = 1'b1;
        start     = poke;
        @(posedge clk); #1;
        out_ready = 1'b0;
        start     = 1'b0;
        @(negedge clk);
        chk("idle_after_handshake", busy, 0);
        chk("no_valid_after_handshake", out_valid, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_sum"}, out_sum, 0);
        chk({tag, "_out_ovf"}, out_ovf, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, with start asserted during reset.
        start = 1'b1;
        #12;
        chk_reset_outputs("reset");
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // Two mid-size samples.
        smp = {32'd70000, 32'd80000};
        run_acc(2, 0, 0, 0, 0);

        // Gaps of two cycles between samples.
        smp = {32'd900000, 32'd500000, 32'd0};
        run_acc(3, 2, 2, 1, 0);

        // Carry-out sets the flag; the next run clears it.
        smp = {32'hFFFF_FFFF, 32'h0000_0002};
        run_acc(2, 0, 1, 0, 0);
        smp = {32'd5};
        run_acc(1, 0, 0, 0, 0);

        // Zero-length: result next cycle, held through stalls with start pokes.
        smp = {};
        run_acc(0, 0, 0, 5, 1);

        // Reset in the middle of an accumulation.
        start = 1'b1;
        len   = LW'(3);
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'd123;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        @(negedge clk);
        reset = 1'b1;
        smp = {32'd7};
        run_acc(1, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("no_output_after_reset", out_valid, 0);

        // Full-length count.
        smp = {};
        for (int i = 0; i < 255; i++) smp.push_back($urandom);
        run_acc(255, 0, 1, 1, 1);

        // Randomized runs, biased toward large values to exercise carries.
        for (int r = 0; r < 40; r++) begin
            int n;
            n = $urandom_range(6, 0);
            smp = {};
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(2, 0) == 0) smp.push_back(32'hFFFF_FF00 | $urandom_range(255, 0));
                else smp.push_back($urandom);
            end
            run_acc(n, 0, 2, $urandom_range(3, 0), 1'($urandom_range(1, 0)));
        end

        chk("scoreboard_drained", exp_sum_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
